// File: rtl/icache_pkg.sv
// Shared definitions for the read-only direct-mapped instruction cache.
//   state_t    : controller states (S_IDLE = 0, S_ALLOC = 1)
//   BLOCK_W    : refill block width in bits (four 32-bit words)
//   MEM_ADDR_W : block address width towards the prefetch controller
//   WORD_W     : fetch word width
//   sel_word() : picks word 0..3 out of a block, word 0 in the low bits
package icache_pkg;

   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned MEM_ADDR_W  = 28;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned PROC_ADDR_W = 30;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ALLOC = 1'b1
   } state_t;

   function automatic logic [WORD_W-1:0] sel_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [1:0]         sel);
      logic [WORD_W-1:0] w;
      case (sel)
         2'd0:    w = blk[31:0];
         2'd1:    w = blk[63:32];
         2'd2:    w = blk[95:64];
         default: w = blk[127:96];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache.
//   clk, rst                      : clock, asynchronous active-low reset (clears valid bits)
//   i_rd_index                    : combinational read index
//   o_rd_valid/o_rd_tag/o_rd_block: contents of the indexed line
//   i_we, i_wr_index, i_wr_tag,
//   i_wr_block                    : synchronous line write; also sets the valid bit
module icache_line_array
   import icache_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 8,
   parameter int unsigned INDEX_W    = 3,
   parameter int unsigned TAG_W      = 25
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] i_rd_index,
   output logic               o_rd_valid,
   output logic [TAG_W-1:0]   o_rd_tag,
   output logic [BLOCK_W-1:0] o_rd_block,
   input  logic               i_we,
   input  logic [INDEX_W-1:0] i_wr_index,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [BLOCK_W-1:0] i_wr_block
);

   logic [NUM_BLOCKS-1:0] r_valid;
   logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_wr_index]  <= i_wr_tag;
         r_data[i_wr_index] <= i_wr_block;
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_block = r_data[i_rd_index];

endmodule

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache between CPU fetch and the prefetch controller.
//   clk, rst             : clock, asynchronous active-low reset
//   proc_read, proc_addr : fetch request, word address ([29:2] block, [1:0] word)
//   proc_rdata           : fetched word, valid when proc_read && !proc_stall
//   proc_stall           : combinational hold
//   mem_read, mem_addr   : registered block read request and block address
//   mem_rdata, mem_ready : refill block and its one-cycle strobe
//   hit_cnt, miss_cnt    : access statistics, present only with ICACHE_STATS_EN defined
module icache_ro
   import icache_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 8,
   parameter int unsigned INDEX_W    = 3,
   parameter int unsigned TAG_W      = 25
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  proc_read,
   input  logic [PROC_ADDR_W-1:0] proc_addr,
   output logic [WORD_W-1:0]     proc_rdata,
   output logic                  proc_stall,
   output logic                  mem_read,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [BLOCK_W-1:0]    mem_rdata,
   input  logic                  mem_ready
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
`endif
);

   state_t                r_state;
   logic                  r_mem_read;
   logic [MEM_ADDR_W-1:0] r_mem_addr;

   logic [INDEX_W-1:0]    w_index;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_line_valid;
   logic [TAG_W-1:0]      w_line_tag;
   logic [BLOCK_W-1:0]    w_line_block;
   logic                  w_hit;
   logic                  w_we;

   assign w_index = proc_addr[2+INDEX_W-1:2];
   assign w_tag   = proc_addr[PROC_ADDR_W-1:2+INDEX_W];

   // Refill always targets the latched block, whatever proc_addr is doing meanwhile.
   assign w_we = (r_state == S_ALLOC) && mem_ready;

   icache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk        (clk),
      .rst        (rst),
      .i_rd_index (w_index),
      .o_rd_valid (w_line_valid),
      .o_rd_tag   (w_line_tag),
      .o_rd_block (w_line_block),
      .i_we       (w_we),
      .i_wr_index (r_mem_addr[INDEX_W-1:0]),
      .i_wr_tag   (r_mem_addr[MEM_ADDR_W-1:INDEX_W]),
      .i_wr_block (mem_rdata)
   );

   assign w_hit = w_line_valid && (w_line_tag == w_tag);

   assign proc_stall = (r_state == S_ALLOC) || (proc_read && !w_hit);
   // Output comes only from the array, never straight from mem_rdata.
   assign proc_rdata = ((r_state == S_IDLE) && proc_read && w_hit) ?
                       sel_word(w_line_block, proc_addr[1:0]) : '0;

   assign mem_read = r_mem_read;
   assign mem_addr = r_mem_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_mem_read <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (proc_read && !w_hit) begin
                  r_mem_addr <= proc_addr[PROC_ADDR_W-1:2];
                  r_mem_read <= 1'b1;
                  r_state    <= S_ALLOC;
               end
            end
            S_ALLOC: begin
               // Drop mem_read together with the fill so the downstream block does not re-arm.
               if (mem_ready) begin
                  r_mem_read <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        r_replay;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_replay   <= 1'b0;
      end else begin
         // The replayed access after a refill was already counted as a miss.
         r_replay <= w_we;
         if (r_state == S_IDLE && proc_read) begin
            if (!w_hit) begin
               r_miss_cnt <= r_miss_cnt + 32'd1;
            end else if (!r_replay) begin
               r_hit_cnt <= r_hit_cnt + 32'd1;
            end
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule
